mem_stage_pipe: RTL and testbench

Parametrised memory (MEM) pipeline stage for the 16-bit processor, successor to the fixed single-cycle data-memory stage.
- Holds an internal synchronous data RAM with configurable width, depth and read latency.
- Adds a valid/ready handshake so the stage can stall upstream (EX) during multi-cycle loads and absorb downstream (WB) back-pressure.
- Adds address range checking.
- Sits between EX and WB and drives the write-back operand.

---
 rtl/mem_stage_pipe.sv | 125 ++++++++++++
 tb/tb_mem_stage_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage between EX and WB, with an internal synchronous data RAM and address range checking.
// Latency: pass, store and RD_LAT=1 loads take 1 cycle; longer loads wait RD_LAT cycles in READ_WAIT.
// Backpressure: in_ready drops while a load is in flight or while an unconsumed result occupies the output slot.
module mem_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] dm_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_dm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ans_dm,
  output logic              addr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                out_valid_q;
  logic                addr_err_q;
  logic [DATA_W-1:0]   ans_dm_q;

  // Operands of a multi-cycle load, captured at accept
  logic [ADDR_W-1:0]   ld_addr_q;
  logic                ld_in_range_q;
  logic                ld_sel_q;
  logic [DATA_W-1:0]   ld_ans_q;

  logic [DATA_W-1:0]   ram_q [DEPTH];

  logic [ADDR_W-1:0]   addr;
  logic                in_range;
  logic                slot_free;
  logic                accept;
  logic                is_load;
  logic                is_store;

  assign addr      = ans_ex[ADDR_W-1:0];
  assign in_range  = (ans_ex[DATA_W-1:ADDR_W] == '0);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_load   = mem_en_ex && !mem_rw_ex;
  assign is_store  = mem_en_ex && mem_rw_ex;

  assign out_valid = out_valid_q;
  assign ans_dm    = ans_dm_q;
  assign addr_err  = addr_err_q;

  // Data RAM write port: stores land on the accept edge; reset blocks a coincident store
  always_ff @(posedge clk) begin
    if (!reset && accept && is_store && in_range) begin
      ram_q[addr] <= dm_data;
    end
  end

  // Stage FSM with registered result slot; RAM is read synchronously into ans_dm
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      ans_dm_q      <= '0;
      addr_err_q    <= 1'b0;
      ld_addr_q     <= '0;
      ld_in_range_q <= 1'b0;
      ld_sel_q      <= 1'b0;
      ld_ans_q      <= '0;
    end else begin
      // WB took the result; any new result written below overrides this
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_load) begin
              // Pass and store both return the ALU result; only stores can flag a range error
              out_valid_q <= 1'b1;
              ans_dm_q    <= ans_ex;
              addr_err_q  <= mem_en_ex && !in_range;
            end else if (RD_LAT == 1) begin
              out_valid_q <= 1'b1;
              ans_dm_q    <= mem_mux_sel_dm ? (in_range ? ram_q[addr] : '0) : ans_ex;
              addr_err_q  <= !in_range;
            end else begin
              state_q       <= READ_WAIT;
              cnt_q         <= 2'(RD_LAT - 1);
              ld_addr_q     <= addr;
              ld_in_range_q <= in_range;
              ld_sel_q      <= mem_mux_sel_dm;
              ld_ans_q      <= ans_ex;
            end
          end
        end
        READ_WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else if (slot_free) begin
            // Completing load holds here until the output slot is free
            out_valid_q <= 1'b1;
            ans_dm_q    <= ld_sel_q ? (ld_in_range_q ? ram_q[ld_addr_q] : '0) : ld_ans_q;
            addr_err_q  <= !ld_in_range_q;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: three instances (RD_LAT = 1, 3, 4) driven through directed scenarios and random traffic.
// Latency: n/a.
// Backpressure: out_ready is driven per scenario, randomly throttled during random traffic.
module tb_mem_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        ordy [3];
  logic        en [3];
  logic        rw [3];
  logic        sel [3];
  logic        err [3];
  logic [15:0] ax [3];
  logic [15:0] dd [3];
  logic [15:0] ad [3];

  int checks = 0;
  int failures = 0;

  // Pre-edge samples taken by step()
  logic        s_acc, s_xfer, s_ov, s_ir, s_err;
  logic [15:0] s_ans;

  logic [15:0] mdl_mem [3][256];
  logic [16:0] exp_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_pipe #(
      .DATA_W(16),
      .ADDR_W(8),
      .RD_LAT(g == 0 ? 1 : g + 2)
    ) u_dut (
      .clk(clk),
      .reset(rst[g]),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .ans_ex(ax[g]),
      .dm_data(dd[g]),
      .mem_en_ex(en[g]),
      .mem_rw_ex(rw[g]),
      .mem_mux_sel_dm(sel[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .ans_dm(ad[g]),
      .addr_err(err[g])
    );
  end

  // Drive one cycle on DUT d at the falling edge, sample just before the rising edge, then advance
  task automatic step(input int d, input bit r, input bit v, input bit e, input bit w, input bit s,
                      input logic [15:0] a, input logic [15:0] dt, input bit orq);
    @(negedge clk);
    rst[d] = r; iv[d] = v; en[d] = e; rw[d] = w; sel[d] = s;
    ax[d] = a; dd[d] = dt; ordy[d] = orq;
    #1;
    s_acc  = v && ir[d] && !r;
    s_xfer = ov[d] && orq && !r;
    s_ov   = ov[d];
    s_ir   = ir[d];
    s_ans  = ad[d];
    s_err  = err[d];
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; en[d] = 1'b0; rw[d] = 1'b0; sel[d] = 1'b0;
      ax[d] = 16'h0; dd[d] = 16'h0; ordy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ov[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid d=%0d got=%b exp=0", d, ov[d]); end
      checks++; if (ad[d] !== 16'h0) begin failures++; $display("FAIL reset_ans_dm d=%0d got=%h exp=0000", d, ad[d]); end
      checks++; if (err[d] !== 1'b0) begin failures++; $display("FAIL reset_addr_err d=%0d got=%b exp=0", d, err[d]); end
      checks++; if (ir[d] !== 1'b1) begin failures++; $display("FAIL reset_in_ready d=%0d got=%b exp=1", d, ir[d]); end
    end
  endtask

  task automatic test_store_then_load();
    step(0, 0, 1, 1, 1, 0, 16'h0012, 16'hBEEF, 1);
    checks++; if (s_acc !== 1'b1) begin failures++; $display("FAIL raw_store_accept got=%b exp=1", s_acc); end
    step(0, 0, 1, 1, 0, 1, 16'h0012, 16'h0000, 1);
    checks++; if (s_acc !== 1'b1) begin failures++; $display("FAIL raw_load_accept got=%b exp=1", s_acc); end
    checks++; if ({s_ov, s_ans} !== {1'b1, 16'h0012}) begin failures++; $display("FAIL raw_store_result got=%b/%h exp=1/0012", s_ov, s_ans); end
    step(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    checks++; if ({s_ov, s_err, s_ans} !== {1'b1, 1'b0, 16'hBEEF}) begin failures++; $display("FAIL raw_load_result got=%b/%b/%h exp=1/0/beef", s_ov, s_err, s_ans); end
  endtask

  task automatic test_load_latency3();
    int lowcnt;
    int got;
    logic [15:0] got_ans;
    lowcnt = 0; got = -1; got_ans = 16'h0;
    step(1, 0, 1, 1, 1, 0, 16'h0005, 16'h1234, 1);
    step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    step(1, 0, 1, 1, 0, 1, 16'h0005, 16'h0000, 1);
    checks++; if (s_acc !== 1'b1) begin failures++; $display("FAIL lat3_accept got=%b exp=1", s_acc); end
    for (int k = 1; k <= 12 && got < 0; k++) begin
      step(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
      if (s_ir === 1'b0) lowcnt++;
      if (s_ov === 1'b1) begin got = k; got_ans = s_ans; end
    end
    checks++; if (lowcnt != 3) begin failures++; $display("FAIL lat3_in_ready_low got=%0d exp=3", lowcnt); end
    checks++; if (got != 4) begin failures++; $display("FAIL lat3_result_cycle got=%0d exp=4", got); end
    checks++; if (got_ans !== 16'h1234) begin failures++; $display("FAIL lat3_data got=%h exp=1234", got_ans); end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    step(0, 0, 1, 0, 0, 0, 16'h00A5, 16'h0000, 1);
    checks++; if (s_acc !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", s_acc); end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0, 1, 16'h0077, 16'h0000, 0);
      if ({s_ov, s_ir, s_acc, s_ans} !== {1'b1, 1'b0, 1'b0, 16'h00A5}) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
    step(0, 0, 1, 0, 0, 1, 16'h0077, 16'h0000, 1);
    checks++; if ({s_acc, s_ans} !== {1'b1, 16'h00A5}) begin failures++; $display("FAIL bp_release got=%b/%h exp=1/00a5", s_acc, s_ans); end
    step(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    checks++; if ({s_ov, s_ans} !== {1'b1, 16'h0077}) begin failures++; $display("FAIL bp_next got=%b/%h exp=1/0077", s_ov, s_ans); end
  endtask

  task automatic test_range();
    step(0, 0, 1, 1, 1, 0, 16'h0000, 16'h1111, 1);
    step(0, 0, 1, 1, 1, 0, 16'h0100, 16'h5555, 1);
    step(0, 0, 1, 1, 0, 1, 16'h0100, 16'h0000, 1);
    checks++; if ({s_err, s_ans} !== {1'b1, 16'h0100}) begin failures++; $display("FAIL range_store got=%b/%h exp=1/0100", s_err, s_ans); end
    step(0, 0, 1, 1, 0, 1, 16'h0000, 16'h0000, 1);
    checks++; if ({s_err, s_ans} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL range_load got=%b/%h exp=1/0000", s_err, s_ans); end
    step(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    checks++; if ({s_err, s_ans} !== {1'b0, 16'h1111}) begin failures++; $display("FAIL range_ram0_intact got=%b/%h exp=0/1111", s_err, s_ans); end
  endtask

  task automatic test_reset_mid_load();
    int seen;
    int got;
    logic [15:0] got_ans;
    seen = 0; got = -1; got_ans = 16'h0;
    step(2, 0, 1, 1, 1, 0, 16'h0007, 16'hCAFE, 1);
    step(2, 0, 1, 1, 0, 1, 16'h0007, 16'h0000, 1);
    step(2, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    step(2, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
    checks++; if (s_ir !== 1'b0) begin failures++; $display("FAIL rml_in_wait got=%b exp=0", s_ir); end
    step(2, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
    step(2, 1, 1, 1, 1, 0, 16'h0007, 16'h9999, 0);
    for (int k = 0; k < 8; k++) begin
      step(2, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
      if (s_ov !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rml_no_output got=%0d exp=0", seen); end
    step(2, 0, 1, 1, 0, 1, 16'h0007, 16'h0000, 1);
    checks++; if (s_acc !== 1'b1) begin failures++; $display("FAIL rml_next_accept got=%b exp=1", s_acc); end
    for (int k = 1; k <= 12 && got < 0; k++) begin
      step(2, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
      if (s_ov === 1'b1) begin got = k; got_ans = s_ans; end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL rml_lat4_cycle got=%0d exp=5", got); end
    checks++; if (got_ans !== 16'hCAFE) begin failures++; $display("FAIL rml_data got=%h exp=cafe", got_ans); end
  endtask

  // Random traffic against a transaction-level model: memory array plus in-order result queue
  task automatic test_random(input int d, input int n);
    int filled;
    int rnd;
    bit v, e, w, s, orq, inr;
    logic [15:0] a, dt, rd;
    logic [16:0] exp_v;
    filled = 0; rnd = 0;
    exp_q.delete();
    for (int guard = 0; guard < 4000 && (filled < 256 || rnd < n); guard++) begin
      if (filled < 256) begin
        v = 1; e = 1; w = 1; s = 0; orq = 1;
        a = 16'(filled); dt = 16'($urandom);
      end else begin
        rnd++;
        v = ($urandom_range(0, 3) != 0); e = ($urandom_range(0, 3) != 0);
        w = $urandom_range(0, 1) != 0; s = $urandom_range(0, 1) != 0;
        orq = ($urandom_range(0, 3) != 0); dt = 16'($urandom);
        a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      end
      step(d, 0, v, e, w, s, a, dt, orq);
      if (s_xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_unexpected d=%0d got=%b/%h exp=none", d, s_err, s_ans);
        end else begin
          exp_v = exp_q.pop_front();
          if ({s_err, s_ans} !== exp_v) begin failures++; $display("FAIL rnd_result d=%0d got=%b/%h exp=%b/%h", d, s_err, s_ans, exp_v[16], exp_v[15:0]); end
        end
      end
      if (s_acc) begin
        inr = (a[15:8] == 8'h00);
        if (!e) exp_v = {1'b0, a};
        else if (w) begin
          exp_v = {!inr, a};
          if (inr) mdl_mem[d][a[7:0]] = dt;
        end else begin
          rd = inr ? mdl_mem[d][a[7:0]] : 16'h0000;
          exp_v = {!inr, s ? rd : a};
        end
        exp_q.push_back(exp_v);
        if (filled < 256) filled++;
      end
    end
    for (int guard = 0; guard < 100 && exp_q.size() > 0; guard++) begin
      step(d, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1);
      if (s_xfer) begin
        exp_v = exp_q.pop_front();
        checks++;
        if ({s_err, s_ans} !== exp_v) begin failures++; $display("FAIL rnd_drain d=%0d got=%b/%h exp=%b/%h", d, s_err, s_ans, exp_v[16], exp_v[15:0]); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_pending d=%0d got=%0d left exp=0", d, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_store_then_load();
    test_load_latency3();
    test_backpressure();
    test_range();
    test_reset_mid_load();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
